// File: rtl/memory_access_stage_if.sv
// Data-cache port of the memory stage: one request channel, one response channel.
// Handshake: req_valid rises with stable addr/write/wdata/wstrb and holds them unchanged until a cycle where req_ready is also high; resp_valid is a single-cycle pulse with no back-pressure.
interface memory_access_stage_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_write;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/memory_access_stage.sv
// Pipeline memory stage: one load/store per op over the data-cache port, registered write-back outputs.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses fault without a request; otherwise the offset is size-aligned.
module memory_access_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_enable,
  input  logic [DATA_W-1:0]     alu_data_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [4:0]            rd_in,
  input  logic                  reg_write_in,
  memory_access_stage_if.master dcache,
  output logic [DATA_W-1:0]     wb_data_out,
  output logic [4:0]            rd_out,
  output logic                  reg_write_out,
  output logic                  misaligned_fault,
  output logic                  memory_done,
  output logic [1:0]            state_dbg
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              is_mem;
  logic [2:0]        off_in;
  logic [2:0]        size_mask;
  logic [2:0]        eff_off;
  logic [7:0]        strb_base;
  logic [2:0]        off_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              load_q;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_val;

  assign accept    = (state == S_IDLE) && memory_enable;
  assign is_mem    = mem_read || mem_write;
  assign off_in    = alu_data_in[2:0];
  assign state_dbg = state;

  always_comb begin
    size_mask = 3'b000;
    strb_base = 8'h01;
    case (mem_size)
      2'd0: begin size_mask = 3'b000; strb_base = 8'h01; end
      2'd1: begin size_mask = 3'b001; strb_base = 8'h03; end
      2'd2: begin size_mask = 3'b011; strb_base = 8'h0F; end
      default: begin size_mask = 3'b111; strb_base = 8'hFF; end
    endcase
  end

  // An aligned offset passes through unchanged; a misaligned one is rounded down to size alignment.
  assign eff_off = off_in & ~size_mask;

`ifdef MEM_MISALIGN_CHECK_EN
  logic fault_in;
  assign fault_in = is_mem && ((off_in & size_mask) != 3'b000);
`else
  assign misaligned_fault = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (memory_enable) begin
          if (!is_mem)
            state_next = S_DONE;
`ifdef MEM_MISALIGN_CHECK_EN
          else if (fault_in)
            state_next = S_DONE;
`endif
          else
            state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (dcache.req_ready)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (dcache.resp_valid)
          state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    lane     = dcache.resp_data >> {off_q, 3'b000};
    load_val = lane;
    case (size_q)
      2'd0: load_val = unsigned_q ? {{(DATA_W-8){1'b0}}, lane[7:0]}
                                  : {{(DATA_W-8){lane[7]}}, lane[7:0]};
      2'd1: load_val = unsigned_q ? {{(DATA_W-16){1'b0}}, lane[15:0]}
                                  : {{(DATA_W-16){lane[15]}}, lane[15:0]};
      2'd2: load_val = unsigned_q ? {{(DATA_W-32){1'b0}}, lane[31:0]}
                                  : {{(DATA_W-32){lane[31]}}, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      dcache.req_valid <= 1'b0;
      dcache.req_addr  <= '0;
      dcache.req_write <= 1'b0;
      dcache.req_wdata <= '0;
      dcache.req_wstrb <= '0;
      memory_done      <= 1'b0;
      wb_data_out      <= '0;
      rd_out           <= '0;
      reg_write_out    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned_fault <= 1'b0;
`endif
      off_q            <= '0;
      size_q           <= '0;
      unsigned_q       <= 1'b0;
      load_q           <= 1'b0;
    end else begin
      state            <= state_next;
      dcache.req_valid <= (state_next == S_REQ);
      memory_done      <= (state_next == S_DONE);
      if (accept) begin
        rd_out           <= rd_in;
        off_q            <= eff_off;
        size_q           <= mem_size;
        unsigned_q       <= mem_unsigned;
        load_q           <= mem_read;
        dcache.req_addr  <= {alu_data_in[ADDR_W-1:3], 3'b000};
        dcache.req_write <= mem_write;
        dcache.req_wdata <= store_data_in << {eff_off, 3'b000};
        dcache.req_wstrb <= strb_base << eff_off;
        wb_data_out      <= is_mem ? '0 : alu_data_in;
        reg_write_out    <= is_mem ? (mem_read && reg_write_in) : reg_write_in;
`ifdef MEM_MISALIGN_CHECK_EN
        misaligned_fault <= fault_in;
        if (fault_in)
          reg_write_out <= 1'b0;
`endif
      end
      // Store acknowledges carry no data; only loads overwrite the write-back value.
      if ((state == S_WAIT) && dcache.resp_valid && load_q)
        wb_data_out <= load_val;
    end
  end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline memory stage, directly downstream of the execute stage. Takes the ALU result (effective address or pass-through value), the store operand and decoded memory controls, and performs one load or store per operation over a valid/ready request, valid-response data-cache port. Produces the write-back value, destination register and a completion pulse for the write-back stage. Loads are byte/half/word/doubleword with sign or zero extension.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data and cache-port width; fixed at 64, giving 8 byte lanes

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- memory_enable  in  1  upstream operation valid (driven from execute completion)
- alu_data_in  in  64  effective address, or result to pass through
- store_data_in  in  64  rs2 contents for stores
- mem_read  in  1  load operation
- mem_write  in  1  store operation; mem_read and mem_write are never both high
- mem_size  in  2  0 byte, 1 half, 2 word, 3 doubleword
- mem_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- rd_in  in  5  destination register
- reg_write_in  in  1  write-back enable
- dcache_req_valid  out  1  request valid
- dcache_req_ready  in  1  cache accepts request
- dcache_req_addr  out  64  8-byte-aligned address (addr[2:0]=0)
- dcache_req_write  out  1  1 store, 0 load
- dcache_req_wdata  out  64  store data shifted to byte lane
- dcache_req_wstrb  out  8  byte enables
- dcache_resp_valid  in  1  load data or store acknowledge
- dcache_resp_data  in  64  aligned 8-byte word
- wb_data_out  out  64  value for write-back
- rd_out  out  5  destination register
- reg_write_out  out  1  write-back enable
- misaligned_fault  out  1  access was misaligned
- memory_done  out  1  one-cycle completion pulse

## Operation
- FSM: IDLE, REQ, WAIT, DONE. All outputs registered.
- IDLE: on memory_enable, latch every input.
  - No-memory op: go to DONE.
  - Misaligned memory op (address not a multiple of 1<<mem_size): go to DONE.
  - Otherwise: go to REQ.
- REQ: dcache_req_valid=1 with stable addr/write/wdata/wstrb until the handshake (valid & ready); then go to WAIT.
- WAIT: on dcache_resp_valid go to DONE.
  - Load: capture data.
  - Store: response is the acknowledge only.
- DONE: memory_done=1 for exactly one cycle, then back to IDLE. memory_enable is ignored in DONE, REQ and WAIT.
- Offset: off = addr[2:0].
- Store wdata: store_data_in << (8*off).
- Store wstrb: ((1<<(1<<mem_size))-1) << off.
- Load result: resp_data >> (8*off), truncated to the access size. Sign-extended unless mem_unsigned; mem_unsigned is ignored for size 3.
- Write-back by op type:
  - No-memory op: wb_data_out = alu_data_in.
  - Store: wb_data_out = 0 and reg_write_out = 0.
  - Load: reg_write_out = reg_write_in.
- Misaligned op:
  - No request is issued.
  - misaligned_fault = 1, reg_write_out = 0, wb_data_out = 0.
- wb_data_out, rd_out, reg_write_out and misaligned_fault hold their values until the next op is latched.
- Reset, including mid-operation:
  - Next state is IDLE.
  - dcache_req_valid, memory_done, reg_write_out and misaligned_fault go to 0.
  - wb_data_out goes to 0 and rd_out to 0.
  - A dcache_resp_valid arriving while IDLE is ignored.

## Timing
- Accept edge t (IDLE sampling memory_enable).
- No-memory or misaligned op: memory_done high in cycle t+1.
- Memory op:
  - dcache_req_valid is high from t+1.
  - If ready in t+1: WAIT from t+2.
  - Response in WAIT cycle w: memory_done in w+1.
  - Minimum load/store latency: 3 cycles from accept to memory_done.
- Back-to-back ops: the earliest next accept is the cycle after DONE, giving a throughput of at most one op per 2 cycles.
- dcache_resp_valid during REQ is a protocol error and is ignored.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - Misalignment is detected as described above.
- MEM_MISALIGN_CHECK_EN undefined:
  - misaligned_fault is tied to 0.
  - The access proceeds using the offset truncated to size alignment (off & ~((1<<mem_size)-1)).
  - No fault path exists in the FSM.

## Test plan
- Non-memory op, alu_data_in=0x1234, rd_in=5, reg_write_in=1 -> memory_done at t+1; wb_data_out=0x1234, rd_out=5, reg_write_out=1; no dcache request.
- LB at address 0x1003, resp_data=0x00000000_80000000 with ready immediate -> req_addr=0x1000, write=0; wb_data_out=0xFFFFFFFF_FFFFFF80. Repeated as LBU -> wb_data_out=0x80.
- SH at 0x2006, store_data_in=0xABCD, ready delayed 3 cycles -> req_valid held 4 cycles with stable fields; wstrb=0xC0, wdata=0xABCD<<48; memory_done one cycle after the ack; reg_write_out=0.
- LW at 0x3002 with MEM_MISALIGN_CHECK_EN defined -> no request; memory_done at t+1; misaligned_fault=1, reg_write_out=0.
- Reset asserted while in WAIT, then a late resp_valid -> req_valid=0 and IDLE after reset; no memory_done; the late response is ignored; the next op completes normally.
